ahb_sram_slave: RTL and testbench

// AHB slave answering the FreeAHB master: single-port word-organised SRAM, fixed base address, programmable wait states.

---
 rtl/ahb_sram_slave.sv | 160 ++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised single-port memory at a fixed base,
// OKAY responses with programmable wait states, two-cycle ERROR on bad access.
module ahb_sram_slave #(
   parameter int unsigned BUS_WDT     = 32,
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic               i_hclk,
   input  logic               i_hreset,
   input  logic               i_hsel,
   input  logic [31:0]        i_haddr,
   input  logic [1:0]         i_htrans,
   input  logic               i_hwrite,
   input  logic [1:0]         i_hsize,
   input  logic [1:0]         i_hburst,
   input  logic [BUS_WDT-1:0] i_hwdata,
   input  logic               i_hready,
   output logic               o_hready,
   output logic [1:0]         o_hresp,
   output logic [BUS_WDT-1:0] o_hrdata
);

   localparam int unsigned BYTES     = BUS_WDT / 8;
   localparam int unsigned LANE_W    = $clog2(BYTES);
   localparam int unsigned IDX_W     = $clog2(DEPTH);
   localparam int unsigned MEM_BYTES = DEPTH * BYTES;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

   state_t             state;
   logic [3:0]         cnt;
   logic               dp_write;
   logic [1:0]         dp_size;
   logic [LANE_W-1:0]  dp_lane;
   logic [IDX_W-1:0]   dp_idx;
   logic [BUS_WDT-1:0] mem [DEPTH];

   logic [31:0]        offset;
   logic [3:0]         amask;
   logic               bad;
   logic               accept;
   logic               acc_ok;
   logic               acc_bad;
   logic               wr_en;
   logic [BYTES-1:0]   wr_be;
   logic [IDX_W-1:0]   rd_idx;
   logic               rd_load;
   logic [BUS_WDT-1:0] rd_word;
   logic               unused;

   assign unused = ^{i_hburst, i_htrans[0]};

   // Byte lanes touched by an access of 2**size bytes starting at lane.
   function automatic logic [BYTES-1:0] lane_mask(input logic [LANE_W-1:0] lane,
                                                  input logic [1:0]        size);
      logic [BYTES-1:0] m;
      int unsigned      lo;
      int unsigned      n;
      m  = '0;
      lo = 32'(lane);
      n  = 32'd1 << size;
      for (int unsigned b = 0; b < BYTES; b++) begin
         m[b] = (b >= lo) && (b < lo + n);
      end
      return m;
   endfunction

   always_comb begin
      offset  = i_haddr - BASE_ADDR;
      amask   = 4'((5'd1 << i_hsize) - 5'd1);
      bad     = (offset >= 32'(MEM_BYTES))
             || ((4'({1'b0, i_haddr[2:0]}) & amask) != 4'd0)
             || (32'(i_hsize) > LANE_W);
      // Only sample an address phase while our own data phase is not stalling.
      accept  = i_hsel & i_hready & i_htrans[1] & o_hready;
      acc_ok  = accept & ~bad;
      acc_bad = accept & bad;
      wr_en   = (state == S_DONE) & dp_write & ~i_hreset;
      wr_be   = lane_mask(dp_lane, dp_size);
      rd_idx  = (state == S_WAIT) ? dp_idx : offset[LANE_W +: IDX_W];
      rd_load = (state == S_WAIT) ? ((cnt == 4'd1) && !dp_write)
                                  : (acc_ok && !i_hwrite && (WAIT_STATES == 0));
      rd_word = mem[rd_idx];
      // A write committing on the same edge wins over the stale array word.
      if (wr_en && (dp_idx == rd_idx)) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (wr_be[b]) rd_word[8*b +: 8] = i_hwdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_hclk) begin
      if (wr_en) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (wr_be[b]) mem[dp_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         o_hready <= 1'b1;
         o_hresp  <= 2'b00;
         o_hrdata <= '0;
         dp_write <= 1'b0;
         dp_size  <= 2'b00;
         dp_lane  <= '0;
         dp_idx   <= '0;
      end else begin
         if (rd_load) o_hrdata <= rd_word;
         if (accept) begin
            dp_write <= i_hwrite;
            dp_size  <= i_hsize;
            dp_lane  <= i_haddr[LANE_W-1:0];
            dp_idx   <= offset[LANE_W +: IDX_W];
         end
         case (state)
            S_WAIT: begin
               if (cnt == 4'd1) begin
                  state    <= S_DONE;
                  cnt      <= '0;
                  o_hready <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_ERR1: begin
               state    <= S_ERR2;
               o_hready <= 1'b1;
               o_hresp  <= 2'b01;
            end
            default: begin
               // IDLE, DONE and ERR2 can all take a new address phase.
               if (acc_bad) begin
                  state    <= S_ERR1;
                  o_hready <= 1'b0;
                  o_hresp  <= 2'b01;
               end else if (acc_ok && (WAIT_STATES != 0)) begin
                  state    <= S_WAIT;
                  cnt      <= 4'(WAIT_STATES);
                  o_hready <= 1'b0;
                  o_hresp  <= 2'b00;
               end else if (acc_ok) begin
                  state    <= S_DONE;
                  o_hready <= 1'b1;
                  o_hresp  <= 2'b00;
               end else begin
                  state    <= S_IDLE;
                  o_hready <= 1'b1;
                  o_hresp  <= 2'b00;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one zero-wait and one two-wait instance
// share the address/data bus; each beat's expected response is queued at accept.
module tb_ahb_sram_slave;

   typedef struct {
      int          id;
      logic [1:0]  trans;
      logic        write;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic        err;
      logic        chk;
      logic [31:0] exp;
   } beat_t;

   logic        clk = 1'b0;
   logic        hreset;
   logic        sel0, sel2;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [1:0]  hsize;
   logic [1:0]  hburst;
   logic [31:0] hwdata;
   logic        rdy0, rdy2;
   logic [1:0]  resp0, resp2;
   logic [31:0] rdata0, rdata2;

   int          checks   = 0;
   int          failures = 0;
   int          cur      = 0;
   int          next_id  = 0;
   beat_t       beats[$];
   beat_t       sb[$];
   beat_t       cur_a;
   logic        a_valid  = 1'b0;

   always #5 clk = ~clk;

   ahb_sram_slave #(.WAIT_STATES(0)) u_dut0 (
      .i_hclk(clk), .i_hreset(hreset), .i_hsel(sel0), .i_haddr(haddr),
      .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
      .i_hwdata(hwdata), .i_hready(rdy0), .o_hready(rdy0), .o_hresp(resp0),
      .o_hrdata(rdata0));

   ahb_sram_slave #(.WAIT_STATES(2)) u_dut2 (
      .i_hclk(clk), .i_hreset(hreset), .i_hsel(sel2), .i_haddr(haddr),
      .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
      .i_hwdata(hwdata), .i_hready(rdy2), .o_hready(rdy2), .o_hresp(resp2),
      .o_hrdata(rdata2));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic cur_ready();
      return (cur == 2) ? rdy2 : rdy0;
   endfunction

   function automatic logic [1:0] cur_resp();
      return (cur == 2) ? resp2 : resp0;
   endfunction

   function automatic logic [31:0] cur_rdata();
      return (cur == 2) ? rdata2 : rdata0;
   endfunction

   task automatic add_beat(input logic [1:0] trans, input logic write, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata, input logic err,
                           input logic chk, input logic [31:0] exp);
      beat_t b;
      b.id = next_id; b.trans = trans; b.write = write; b.addr = addr; b.size = size;
      b.wdata = wdata; b.err = err; b.chk = chk; b.exp = exp;
      next_id++;
      beats.push_back(b);
   endtask

   task automatic drive_addr();
      if (beats.size() > 0) begin
         cur_a   = beats.pop_front();
         a_valid = 1'b1;
         htrans  = cur_a.trans;
         haddr   = cur_a.addr;
         hwrite  = cur_a.write;
         hsize   = cur_a.size;
      end else begin
         a_valid = 1'b0;
         htrans  = 2'd0;
         haddr   = 32'h0;
         hwrite  = 1'b0;
         hsize   = 2'd0;
      end
   endtask

   // Pipelined master: address phase of beat n+1 overlaps the data phase of beat n.
   task automatic run_beats();
      beat_t       e;
      logic        have_dp = 1'b0;
      int          waits   = 0;
      logic [1:0]  fresp   = 2'd0;
      int          guard   = 0;
      int          ws;
      logic        rdy;
      logic [1:0]  rsp;
      logic [31:0] rd;
      logic [31:0] nw;
      ws = (cur == 2) ? 2 : 0;
      @(posedge clk); #1;
      drive_addr();
      while ((a_valid || have_dp) && guard < 500) begin
         guard++;
         @(negedge clk);
         rdy = cur_ready();
         rsp = cur_resp();
         rd  = cur_rdata();
         if (have_dp) begin
            if (!rdy) begin
               waits++;
               if (waits == 1) fresp = rsp;
            end else begin
               e = sb.pop_front();
               check_eq($sformatf("b%0d_waits", e.id), 32'(waits),
                        e.err ? 32'd1 : (e.trans[1] ? 32'(ws) : 32'd0));
               if (waits > 0)
                  check_eq($sformatf("b%0d_resp_first", e.id), 32'(fresp), e.err ? 32'd1 : 32'd0);
               check_eq($sformatf("b%0d_resp", e.id), 32'(rsp), e.err ? 32'd1 : 32'd0);
               if (e.chk) check_eq($sformatf("b%0d_rdata", e.id), rd, e.exp);
               have_dp = 1'b0;
            end
         end
         if (rdy) begin
            nw = hwdata;
            if (a_valid) begin
               sb.push_back(cur_a);
               have_dp = 1'b1;
               waits   = 0;
               nw      = cur_a.wdata;
            end
            @(posedge clk); #1;
            hwdata = nw;
            drive_addr();
         end else begin
            @(posedge clk); #1;
         end
      end
      check_eq("run_drain", {31'd0, have_dp}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      hreset = 1'b1; sel0 = 1'b0; sel2 = 1'b0; haddr = 32'h0; htrans = 2'd0;
      hwrite = 1'b0; hsize = 2'd0; hburst = 2'd0; hwdata = 32'h0;
      repeat (3) @(posedge clk);
      #1 hreset = 1'b0;
      @(negedge clk);
      check_eq("rst_hready0", {31'd0, rdy0}, 32'd1);
      check_eq("rst_hresp0", {30'd0, resp0}, 32'd0);
      check_eq("rst_hrdata0", rdata0, 32'd0);
      check_eq("rst_hready2", {31'd0, rdy2}, 32'd1);
      check_eq("rst_hrdata2", rdata2, 32'd0);

      // Zero-wait instance.
      cur = 0; sel0 = 1'b1; sel2 = 1'b0;
      add_beat(2, 1, 32'h2000_0000, 2, 32'hDEAD_BEEF, 0, 0, 0);
      add_beat(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      add_beat(2, 0, 32'h2000_0000, 2, 32'h0, 0, 1, 32'hDEAD_BEEF);
      add_beat(2, 1, 32'h2000_0004, 2, 32'h1122_3344, 0, 0, 0);
      add_beat(2, 1, 32'h2000_0005, 0, 32'h0000_A500, 0, 0, 0);
      add_beat(2, 1, 32'h2000_0006, 1, 32'hBEEF_0000, 0, 0, 0);
      add_beat(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      add_beat(2, 0, 32'h2000_0004, 2, 32'h0, 0, 1, 32'hBEEF_A544);
      add_beat(2, 1, 32'h2000_0010, 2, 32'h55AA_55AA, 0, 0, 0);
      add_beat(2, 0, 32'h2000_0010, 2, 32'h0, 0, 1, 32'h55AA_55AA);
      add_beat(2, 1, 32'h2000_0011, 0, 32'h0000_7700, 0, 0, 0);
      add_beat(2, 0, 32'h2000_0010, 2, 32'h0, 0, 1, 32'h55AA_77AA);
      add_beat(2, 1, 32'h2000_0FFC, 2, 32'h0BAD_CAFE, 0, 0, 0);
      add_beat(3, 0, 32'h2000_0FFC, 2, 32'h0, 0, 1, 32'h0BAD_CAFE);
      add_beat(2, 1, 32'h2000_1000, 2, 32'hFFFF_FFFF, 1, 0, 0);
      add_beat(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      add_beat(2, 1, 32'h2000_0001, 1, 32'hFFFF_FFFF, 1, 0, 0);
      add_beat(2, 1, 32'h1FFF_FFFC, 2, 32'hFFFF_FFFF, 1, 0, 0);
      add_beat(2, 0, 32'h2000_0008, 3, 32'h0, 1, 0, 0);
      add_beat(1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      add_beat(2, 0, 32'h2000_0000, 2, 32'h0, 0, 1, 32'hDEAD_BEEF);
      run_beats();

      // Two-wait instance.
      cur = 2; sel0 = 1'b0; sel2 = 1'b1;
      add_beat(2, 1, 32'h2000_0000, 2, 32'hCAFE_F00D, 0, 0, 0);
      add_beat(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      add_beat(2, 0, 32'h2000_0000, 2, 32'h0, 0, 1, 32'hCAFE_F00D);
      add_beat(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      add_beat(2, 1, 32'h2000_0004, 0, 32'h0000_0042, 0, 0, 0);
      add_beat(2, 0, 32'h2000_0004, 0, 32'h0, 0, 0, 0);
      add_beat(2, 1, 32'h2000_1000, 2, 32'h0, 1, 0, 0);
      run_beats();

      // Reset during the first wait cycle of a write drops the write.
      haddr = 32'h2000_0000; hwrite = 1'b1; hsize = 2'd2; htrans = 2'd2;
      @(posedge clk); #1;
      hwdata = 32'h1234_5678; htrans = 2'd0; hwrite = 1'b0;
      @(negedge clk);
      check_eq("rstw_wait1", {31'd0, rdy2}, 32'd0);
      hreset = 1'b1;
      @(posedge clk); #1;
      hreset = 1'b0;
      @(negedge clk);
      check_eq("rstw_hready", {31'd0, rdy2}, 32'd1);
      check_eq("rstw_hresp", {30'd0, resp2}, 32'd0);
      check_eq("rstw_hrdata", rdata2, 32'd0);
      add_beat(2, 0, 32'h2000_0000, 2, 32'h0, 0, 1, 32'hCAFE_F00D);
      run_beats();

      sel2 = 1'b0;
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
